// File: rtl/uart_rx_deframer.sv
// UART receive deframer: synchronises rx_serial, samples each bit at its centre using the
// oversample enable, and hands the byte and parity bit to the downstream parity checker.
//
// state  | meaning
// IDLE   | line idle, waiting for a low sample on a tick
// START  | counting to the middle of the start bit to confirm it
// DATA   | sampling DATA_WIDTH data bits, LSB first
// PARITY | sampling the parity bit
// STOP   | sampling the stop bit, then delivering the frame
module uart_rx_deframer #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baud_tick,
  input  logic                  rx_serial,
  output logic [DATA_WIDTH-1:0] rx_data_in,
  output logic                  rx_in,
  output logic                  parity_load,
  output logic                  stop_bit_error,
  output logic                  false_start,
  output logic                  busy
);

  localparam int SW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [SW-1:0] S_HALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST = SW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, sync2_q;
  logic [SW-1:0]         s_cnt_q, s_cnt_d;
  logic [BW-1:0]         b_cnt_q, b_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  rx_in_q, rx_in_d;
  logic                  parity_load_q, parity_load_d;
  logic                  stop_err_q, stop_err_d;
  logic                  false_start_q, false_start_d;
  logic                  busy_q, busy_d;
  logic                  rxs;

  assign rxs = sync2_q;

  always_comb begin
    state_d       = state_q;
    s_cnt_d       = s_cnt_q;
    b_cnt_d       = b_cnt_q;
    shift_d       = shift_q;
    par_d         = par_q;
    rx_data_d     = rx_data_q;
    rx_in_d       = rx_in_q;
    stop_err_d    = stop_err_q;
    parity_load_d = 1'b0;
    false_start_d = 1'b0;
    if (baud_tick) begin
      case (state_q)
        IDLE: begin
          if (!rxs) begin
            state_d = START;
            s_cnt_d = '0;
          end
        end
        START: begin
          if (s_cnt_q == S_HALF) begin
            s_cnt_d = '0;
            if (!rxs) begin
              state_d = DATA;
              b_cnt_d = '0;
            end else begin
              state_d       = IDLE;
              false_start_d = 1'b1;
            end
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
        DATA: begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d = '0;
            shift_d = {rxs, shift_q[DATA_WIDTH-1:1]};
            if (b_cnt_q == B_LAST) state_d = PARITY;
            else                   b_cnt_d = b_cnt_q + BW'(1);
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
        PARITY: begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d = '0;
            par_d   = rxs;
            state_d = STOP;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
        STOP: begin
          if (s_cnt_q == S_LAST) begin
            s_cnt_d       = '0;
            rx_data_d     = shift_q;
            rx_in_d       = par_q;
            stop_err_d    = ~rxs;
            parity_load_d = 1'b1;
            state_d       = IDLE;
          end else begin
            s_cnt_d = s_cnt_q + SW'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      s_cnt_q       <= '0;
      b_cnt_q       <= '0;
      shift_q       <= '0;
      par_q         <= 1'b0;
      rx_data_q     <= '0;
      rx_in_q       <= 1'b0;
      parity_load_q <= 1'b0;
      stop_err_q    <= 1'b0;
      false_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= rx_serial;
      sync2_q       <= sync1_q;
      s_cnt_q       <= s_cnt_d;
      b_cnt_q       <= b_cnt_d;
      shift_q       <= shift_d;
      par_q         <= par_d;
      rx_data_q     <= rx_data_d;
      rx_in_q       <= rx_in_d;
      parity_load_q <= parity_load_d;
      stop_err_q    <= stop_err_d;
      false_start_q <= false_start_d;
      busy_q        <= busy_d;
    end
  end

  assign rx_data_in     = rx_data_q;
  assign rx_in          = rx_in_q;
  assign parity_load    = parity_load_q;
  assign stop_bit_error = stop_err_q;
  assign false_start    = false_start_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Bench for uart_rx_deframer: frame table plus hand-written corner sequences, with a
// scoreboard of expected deliveries checked on every parity_load pulse.
module tb_uart_rx_deframer;

  logic       clk = 1'b0;
  logic       rst, baud_tick, rx_serial;
  logic [7:0] rx_data_in;
  logic       rx_in, parity_load, stop_bit_error, false_start, busy;

  uart_rx_deframer #(.DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx_serial(rx_serial),
    .rx_data_in(rx_data_in), .rx_in(rx_in), .parity_load(parity_load),
    .stop_bit_error(stop_bit_error), .false_start(false_start), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stopb;
    logic [7:0] exp_data;
    logic       exp_par;
    logic       exp_serr;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       serr;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   pl_cnt = 0;
  int   fs_cnt = 0;
  int   period = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (false_start === 1'b1) fs_cnt++;
    if (parity_load === 1'b1) begin
      exp_t e;
      pl_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_parity_load", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("rx_data_in", 32'(rx_data_in), 32'(e.data));
        chk("rx_in", 32'(rx_in), 32'(e.par));
        chk("stop_bit_error", 32'(stop_bit_error), 32'(e.serr));
      end
    end
  end

  task automatic step(input logic tk);
    @(negedge clk);
    baud_tick = tk;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      repeat (period - 1) step(1'b0);
      step(1'b1);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_serial = b;
    ticks(16);
  endtask

  task automatic push(input logic [7:0] d, input logic p, input logic stopb);
    exp_t e;
    e.data = d;
    e.par  = p;
    e.serr = ~stopb;
    sb.push_back(e);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stopb,
                            input int stall_bit);
    int pl0;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      if (i == stall_bit) begin
        pl0 = pl_cnt;
        repeat (100) step(1'b0);
        chk("stall_busy", 32'(busy), 32'd1);
        chk("stall_no_strobe", 32'(pl_cnt - pl0), 32'd0);
      end
    end
    send_bit(p);
    send_bit(stopb);
    rx_serial = 1'b1;
  endtask

  vec_t vecs[5];

  initial begin
    int pl0, fs0, exp_fs;
    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[2] = '{8'h81, 1'b0, 1'b1, 8'h81, 1'b0, 1'b0};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[4] = '{8'hC3, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b1};

    rst = 1'b1; rx_serial = 1'b1; baud_tick = 1'b0;
    repeat (3) step(1'b0);
    rst = 1'b0;
    step(1'b0);
    chk("rst_rx_data_in", 32'(rx_data_in), 32'd0);
    chk("rst_rx_in", 32'(rx_in), 32'd0);
    chk("rst_parity_load", 32'(parity_load), 32'd0);
    chk("rst_stop_bit_error", 32'(stop_bit_error), 32'd0);
    chk("rst_false_start", 32'(false_start), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // A stop bit of 0 leaves the line low after the stop sample, so the FSM
    // re-enters START and then sees the line high at mid-bit: one false start.
    pl0 = pl_cnt; fs0 = fs_cnt; exp_fs = 0;
    ticks(8);
    for (int i = 0; i < 5; i++) begin
      push(vecs[i].data, vecs[i].par, vecs[i].stopb);
      chk("table_exp_serr", 32'(sb[sb.size()-1].serr), 32'(vecs[i].exp_serr));
      send_frame(vecs[i].data, vecs[i].par, vecs[i].stopb, -1);
      ticks(12);
      if (!vecs[i].stopb) exp_fs++;
      chk("table_held_data", 32'(rx_data_in), 32'(vecs[i].exp_data));
      chk("table_held_par", 32'(rx_in), 32'(vecs[i].exp_par));
      chk("table_busy_idle", 32'(busy), 32'd0);
    end
    chk("table_pulses", 32'(pl_cnt - pl0), 32'd5);
    chk("table_false_starts", 32'(fs_cnt - fs0), 32'(exp_fs));
    chk("table_sb_empty", 32'(sb.size()), 32'd0);

    pl0 = pl_cnt; fs0 = fs_cnt;
    rx_serial = 1'b0;
    ticks(4);
    rx_serial = 1'b1;
    ticks(24);
    chk("glitch_false_start", 32'(fs_cnt - fs0), 32'd1);
    chk("glitch_no_load", 32'(pl_cnt - pl0), 32'd0);
    chk("glitch_busy", 32'(busy), 32'd0);

    pl0 = pl_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx_serial = 1'b1;
    ticks(8);
    chk("midframe_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    step(1'b0);
    step(1'b0);
    rst = 1'b0;
    step(1'b0);
    chk("rst_mid_data", 32'(rx_data_in), 32'd0);
    chk("rst_mid_rx_in", 32'(rx_in), 32'd0);
    chk("rst_mid_serr", 32'(stop_bit_error), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_no_load", 32'(pl_cnt - pl0), 32'd0);
    ticks(20);
    push(8'h12, 1'b1, 1'b1);
    send_frame(8'h12, 1'b1, 1'b1, -1);
    ticks(12);
    chk("after_rst_pulses", 32'(pl_cnt - pl0), 32'd1);

    period = 5;
    pl0 = pl_cnt;
    push(8'h55, 1'b0, 1'b1);
    push(8'hFE, 1'b1, 1'b1);
    send_frame(8'h55, 1'b0, 1'b1, -1);
    chk("b2b_first_pulse", 32'(pl_cnt - pl0), 32'd1);
    send_bit(1'b0);
    chk("b2b_hold_data", 32'(rx_data_in), 32'h55);
    chk("b2b_hold_par", 32'(rx_in), 32'd0);
    for (int i = 0; i < 8; i++) send_bit(8'hFE >> i);
    send_bit(1'b1);
    send_bit(1'b1);
    rx_serial = 1'b1;
    ticks(12);
    chk("b2b_pulses", 32'(pl_cnt - pl0), 32'd2);
    period = 1;

    pl0 = pl_cnt;
    push(8'h6B, 1'b1, 1'b1);
    send_frame(8'h6B, 1'b1, 1'b1, 3);
    ticks(12);
    chk("stall_pulses", 32'(pl_cnt - pl0), 32'd1);
    chk("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_deframer.md
Name: uart_rx_deframer

Overview:
Receive-side serial front end of the UART. It synchronises the serial line, detects start bits, and samples data, parity and stop bits mid-bit using a 16x oversampling enable. It delivers the assembled byte plus the received parity bit to the downstream parity checker, and flags completion with a one-cycle parity_load strobe. Frame-level errors (stop bit, false start) are also reported here; parity evaluation stays in the downstream stage.

Parameters:
DATA_WIDTH, 8, data bits per frame, LSB first
OVERSAMPLE, 16, baud_tick pulses per bit period; power of two, min 8

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
baud_tick  input  1  oversample enable; one-clk pulse, OVERSAMPLE per bit
rx_serial  input  1  asynchronous serial line, idle high
rx_data_in  output  DATA_WIDTH  assembled byte, registered, held until next frame completes
rx_in  output  1  received parity bit, registered, held with rx_data_in
parity_load  output  1  one-clk pulse: rx_data_in/rx_in newly valid
stop_bit_error  output  1  1 = sampled stop bit was 0; updated with parity_load
false_start  output  1  one-clk pulse: start bit not low at mid-bit
busy  output  1  1 whenever state != IDLE

Behaviour:
- Reset (clk edge with rst=1): state IDLE, counters 0, sync flops 1, rx_data_in 0, rx_in 0, parity_load 0, stop_bit_error 0, false_start 0, busy 0. Reset mid-frame abandons the frame, with no strobe.
- Input: 2-flop synchroniser on rx_serial, reset value 1. rxs denotes the 2nd flop output. This adds 2 clk of latency.
- State and counters advance only on clk edges with baud_tick=1. Otherwise all state holds, except that parity_load and false_start return to 0.
- Counters:
  - s_cnt: log2(OVERSAMPLE) bits.
  - b_cnt: counts 0..DATA_WIDTH-1.
- FSM:
  - IDLE: on tick with rxs=0 -> START, s_cnt=0.
  - START: on tick, if s_cnt==OVERSAMPLE/2-1:
    - rxs=0 -> DATA, s_cnt=0, b_cnt=0.
    - rxs=1 -> IDLE, false_start pulse.
    - Otherwise s_cnt++.
  - DATA: on tick, if s_cnt==OVERSAMPLE-1:
    - Shift rxs into MSB of shift reg (LSB-first assembly), s_cnt=0.
    - If b_cnt==DATA_WIDTH-1 -> PARITY, else b_cnt++.
    - Otherwise s_cnt++.
  - PARITY: on tick at s_cnt==OVERSAMPLE-1, capture rxs into parity reg, s_cnt=0 -> STOP.
  - STOP: on tick at s_cnt==OVERSAMPLE-1, on the same clk edge:
    - rx_data_in <= shift reg.
    - rx_in <= parity reg.
    - stop_bit_error <= ~rxs.
    - parity_load <= 1.
    - -> IDLE.
- Sample point: mid-bit, OVERSAMPLE ticks after the centre of the previous bit.
- Outputs to downstream are registered on the same edge as parity_load rises. They are stable for the full pulse and hold afterwards (the downstream checker is level-sensitive).
- A stop-bit error still delivers data and parity_load; no resync hunt.
- Back-to-back frames: a start bit arriving immediately after the STOP sample is detected from IDLE on the next tick with rxs=0.
- Line held low (break): the frame completes with stop_bit_error=1. Because the line is still low, the FSM re-enters START and again completes frames with stop_bit_error=1 until the line returns high. This is accepted behaviour.
- busy = (state != IDLE), registered.

Test Plan:
- 0xA5 frame: start, bits 1,0,1,0,0,1,0,1, parity 0, stop 1; baud_tick every clk. -> Exactly one parity_load pulse; rx_data_in=0xA5, rx_in=0, stop_bit_error=0, false_start never 1.
- Glitch: rx_serial low for 4 ticks then high. -> false_start pulses once at tick 8; no parity_load; busy returns to 0; state IDLE.
- 0x3C frame with stop bit 0. -> parity_load pulses; rx_data_in=0x3C, stop_bit_error=1. Next good frame 0x81 -> stop_bit_error=0, rx_data_in=0x81.
- Reset asserted during DATA bit 4 of 0xFF frame. -> No parity_load; outputs at reset values. Following 0x12 frame -> rx_data_in=0x12, rx_in as sent.
- baud_tick every 5th clk, two back-to-back frames 0x55 (parity 0) then 0xFE (parity 1) with no idle gap. -> Two parity_load pulses. Values 0x55/0 then 0xFE/1. rx_data_in holds 0x55 between pulses.
- baud_tick forced 0 for 100 clk mid-frame, then resumed. -> Frame still decodes correctly; no spurious strobes during the stall.
